// File: rtl/mult_pipe_unit_pkg.sv
// Purpose: shared encodings and default parameters for the pipelined multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pipe_unit_pkg;

    // Operation select carried alongside each op down the pipe.
    typedef enum logic [1:0] {
        MULT_TYPE_LO = 2'b00,   // MUL    : low half, signed x signed
        MULT_TYPE_SS = 2'b01,   // MULH   : high half, signed x signed
        MULT_TYPE_SU = 2'b10,   // MULHSU : high half, signed x unsigned
        MULT_TYPE_UU = 2'b11    // MULHU  : high half, unsigned x unsigned
    } mult_type_t;

    localparam int DEFAULT_XLEN   = 32;
    localparam int DEFAULT_STAGES = 3;

endpackage

// File: rtl/mult_pipe_core.sv
// Purpose: signed (XLEN+1)x(XLEN+1) multiplier as a STAGES-deep register chain.
// Latency: STAGES clock enables from operand capture to p; stage 0 holds the operands.
// Backpressure: every register holds while en=0; no reset, validity is tracked by the caller.
//
// Ports: clk, en (shift enable), a/b (sign-extended operands, XLEN+1 bits),
//        p (product truncated to 2*XLEN bits). Replaceable by vendor IP of equal latency.
module mult_pipe_core #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3
) (
    input  logic                clk,
    input  logic                en,
    input  logic [XLEN:0]       a,
    input  logic [XLEN:0]       b,
    output logic [2*XLEN-1:0]   p
);

    logic [XLEN:0]     a_q;
    logic [XLEN:0]     b_q;
    logic [2*XLEN-1:0] a_wide;
    logic [2*XLEN-1:0] b_wide;
    logic [2*XLEN-1:0] prod;

    always_ff @(posedge clk) begin
        if (en) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Sign-extend to the result width; a modular product of the extended
    // values equals the signed product truncated to 2*XLEN bits.
    assign a_wide = {{(XLEN-1){a_q[XLEN]}}, a_q};
    assign b_wide = {{(XLEN-1){b_q[XLEN]}}, b_q};
    assign prod   = a_wide * b_wide;

    generate
        if (STAGES == 1) begin : g_single
            assign p = prod;
        end else begin : g_chain
            logic [2*XLEN-1:0] pipe_q [STAGES-1];
            always_ff @(posedge clk) begin
                if (en) begin
                    pipe_q[0] <= prod;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign p = pipe_q[STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/mult_pipe_unit.sv
// Purpose: RV32M/RV64M MUL/MULH/MULHSU/MULHU unit with tags, flush, hazard bitmap, in-flight count.
// Latency: STAGES cycles from accept to out_valid, plus one cycle per stalled cycle; 1 op/cycle.
// Backpressure: whole pipe (tags and datapath) holds while out_valid & ~out_ready; in_ready drops.
//
// Ports: in_valid/in_ready/in_a/in_b/in_type/in_rd (issue side), flush (kill in-flight),
//        out_valid/out_ready/out_data/out_rd (writeback side), hazard_flags (pending rd bitmap),
//        inflight (occupied stages, including rd=0 ops that drain silently).
module mult_pipe_unit
    import mult_pipe_unit_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int STAGES = DEFAULT_STAGES,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [1:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [4:0]        out_rd,
    output logic [31:0]       hazard_flags,
    output logic [CNT_W-1:0]  inflight
);

    logic [STAGES-1:0] vld_q;
    logic [4:0]        rd_q  [STAGES];
    mult_type_t        typ_q [STAGES];

    logic              advance;
    logic              accept;
    logic              retire;
    logic              last_vld;
    mult_type_t        in_typ;
    logic              a_sign;
    logic              b_sign;
    logic [2*XLEN-1:0] prod;

    assign in_typ   = mult_type_t'(in_type);
    assign last_vld = vld_q[STAGES-1];

    // A dropped (rd=0) op at the exit never raises out_valid, so it never stalls.
    assign out_valid = last_vld & (rd_q[STAGES-1] != 5'd0);
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance & ~flush;
    assign accept    = in_valid & in_ready;
    // Any valid op leaving the last stage, delivered or dropped, frees a slot.
    assign retire    = last_vld & advance;

    assign a_sign = (in_typ != MULT_TYPE_UU) & in_a[XLEN-1];
    assign b_sign = ((in_typ == MULT_TYPE_LO) | (in_typ == MULT_TYPE_SS)) & in_b[XLEN-1];

    mult_pipe_core #(
        .XLEN   (XLEN),
        .STAGES (STAGES)
    ) u_core (
        .clk (clk),
        .en  (advance),
        .a   ({a_sign, in_a}),
        .b   ({b_sign, in_b}),
        .p   (prod)
    );

    // Valid bits and occupancy: reset beats flush, flush beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            inflight <= '0;
        end else if (flush) begin
            vld_q    <= '0;
            inflight <= '0;
        end else begin
            if (advance) begin
                vld_q[0] <= accept;
                for (int i = 1; i < STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
            inflight <= inflight + CNT_W'(accept) - CNT_W'(retire);
        end
    end

    // Tags follow the datapath enable; their contents only matter where the valid bit is set.
    always_ff @(posedge clk) begin
        if (advance) begin
            rd_q[0]  <= in_rd;
            typ_q[0] <= in_typ;
            for (int i = 1; i < STAGES; i++) begin
                rd_q[i]  <= rd_q[i-1];
                typ_q[i] <= typ_q[i-1];
            end
        end
    end

    always_comb begin
        out_data = '0;
        out_rd   = 5'd0;
        if (last_vld) begin
            out_rd   = rd_q[STAGES-1];
            out_data = (typ_q[STAGES-1] == MULT_TYPE_LO) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // Pending-write bitmap: every occupied stage plus the op being accepted now.
    always_comb begin
        hazard_flags = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (vld_q[s]) begin
                hazard_flags[rd_q[s]] = 1'b1;
            end
        end
        if (accept) begin
            hazard_flags[in_rd] = 1'b1;
        end
        hazard_flags[0] = 1'b0;
    end

endmodule

// File: tb/tb_mult_pipe_unit.sv
module tb_mult_pipe_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 32-bit, 3-stage instance
    logic        v1, ordy1, fl1;
    logic [31:0] a1, b1;
    logic [1:0]  t1;
    logic [4:0]  rd1;
    logic        irdy1, ov1;
    logic [31:0] od1;
    logic [4:0]  ord1;
    logic [31:0] hz1;
    logic [1:0]  inf1;

    // 64-bit, 1-stage instance
    logic        v2, ordy2, fl2;
    logic [63:0] a2, b2;
    logic [1:0]  t2;
    logic [4:0]  rd2;
    logic        irdy2, ov2;
    logic [63:0] od2;
    logic [4:0]  ord2;
    logic [31:0] hz2;
    logic [0:0]  inf2;

    int checks   = 0;
    int failures = 0;

    mult_pipe_unit #(.XLEN(32), .STAGES(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(irdy1), .in_a(a1), .in_b(b1),
        .in_type(t1), .in_rd(rd1), .flush(fl1), .out_valid(ov1), .out_ready(ordy1),
        .out_data(od1), .out_rd(ord1), .hazard_flags(hz1), .inflight(inf1)
    );

    mult_pipe_unit #(.XLEN(64), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(irdy2), .in_a(a2), .in_b(b2),
        .in_type(t2), .in_rd(rd2), .flush(fl2), .out_valid(ov2), .out_ready(ordy2),
        .out_data(od2), .out_rd(ord2), .hazard_flags(hz2), .inflight(inf2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v1 = 0; a1 = 0; b1 = 0; t1 = 0; rd1 = 0; fl1 = 0; ordy1 = 1;
        v2 = 0; a2 = 0; b2 = 0; t2 = 0; rd2 = 0; fl2 = 0; ordy2 = 1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", ov1); end
        checks++; if (od1 !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", od1); end
        checks++; if (ord1 !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%0d exp=0", ord1); end
        checks++; if (hz1 !== 32'h0) begin failures++; $display("FAIL reset_hazard got=%h exp=0", hz1); end
        checks++; if (inf1 !== 2'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inf1); end
        checks++; if (irdy1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", irdy1); end
        checks++; if (irdy2 !== 1'b1 || ov2 !== 1'b0) begin failures++; $display("FAIL reset_dut2 in_ready=%0b out_valid=%0b exp 1/0", irdy2, ov2); end
        step();
    endtask

    task automatic test_product_select();
        logic [31:0] ea [4];
        logic [31:0] eb [4];
        logic [31:0] ex [4];
        ea[0] = 32'd7;        eb[0] = 32'hFFFFFFFD; ex[0] = 32'hFFFFFFEB;
        ea[1] = 32'h80000000; eb[1] = 32'h80000000; ex[1] = 32'h40000000;
        ea[2] = 32'hFFFFFFFF; eb[2] = 32'hFFFFFFFF; ex[2] = 32'hFFFFFFFF;
        ea[3] = 32'hFFFFFFFF; eb[3] = 32'hFFFFFFFF; ex[3] = 32'hFFFFFFFE;
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c < 4) begin
                v1 = 1; a1 = ea[c]; b1 = eb[c]; t1 = 2'(c); rd1 = 5'(c + 1);
            end
            #1;
            if (c < 3 || c == 7) begin
                checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL prod_idle_valid cyc=%0d got=%0b exp=0", c, ov1); end
            end else begin
                checks++;
                if (ov1 !== 1'b1 || od1 !== ex[c-3] || ord1 !== 5'(c - 2)) begin
                    failures++;
                    $display("FAIL prod_result cyc=%0d got v=%0b d=%h rd=%0d exp v=1 d=%h rd=%0d", c, ov1, od1, ord1, ex[c-3], c - 2);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ex [3];
        ex[0] = 32'd6; ex[1] = 32'd20; ex[2] = 32'd42;
        for (int c = 0; c < 12; c++) begin
            idle();
            ordy1 = (c >= 8);
            if (c < 3) begin
                v1 = 1; a1 = 32'(2 * c + 2); b1 = 32'(2 * c + 3); t1 = 2'b00; rd1 = 5'(6 + c);
            end
            #1;
            if (c >= 3 && c <= 7) begin
                checks++;
                if (irdy1 !== 1'b0 || ov1 !== 1'b1 || od1 !== 32'd6 || ord1 !== 5'd6 || inf1 !== 2'd3) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got rdy=%0b v=%0b d=%h rd=%0d inf=%0d exp 0/1/6/6/3", c, irdy1, ov1, od1, ord1, inf1);
                end
            end else if (c >= 8 && c <= 10) begin
                checks++;
                if (ov1 !== 1'b1 || od1 !== ex[c-8] || ord1 !== 5'(c - 2)) begin
                    failures++;
                    $display("FAIL bp_drain cyc=%0d got v=%0b d=%h rd=%0d exp v=1 d=%h rd=%0d", c, ov1, od1, ord1, ex[c-8], c - 2);
                end
            end else if (c == 11) begin
                checks++;
                if (ov1 !== 1'b0 || inf1 !== 2'd0) begin
                    failures++; $display("FAIL bp_empty got v=%0b inf=%0d exp 0/0", ov1, inf1);
                end
            end
            step();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 3) begin
                v1 = 1; a1 = 32'd3; b1 = 32'd3; t1 = 2'b00; rd1 = 5'(10 + c);
            end
            if (c == 2) fl1 = 1;
            #1;
            if (c == 2) begin
                checks++; if (irdy1 !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", irdy1); end
            end
            if (c == 3) begin
                checks++; if (inf1 !== 2'd0) begin failures++; $display("FAIL flush_inflight got=%0d exp=0", inf1); end
                checks++; if (hz1 !== 32'h0) begin failures++; $display("FAIL flush_hazard got=%h exp=0", hz1); end
            end
            if (c >= 3) begin
                checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL flush_out_valid cyc=%0d got=%0b exp=0", c, ov1); end
            end
            step();
        end
    endtask

    task automatic test_x0_dest();
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) begin
                v1 = 1; a1 = 32'd5; b1 = 32'd9; t1 = 2'b00; rd1 = 5'd0;
            end
            #1;
            checks++; if (hz1[0] !== 1'b0) begin failures++; $display("FAIL x0_hazard0 cyc=%0d got=%0b exp=0", c, hz1[0]); end
            checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL x0_out_valid cyc=%0d got=%0b exp=0", c, ov1); end
            if (c >= 1) begin
                checks++;
                if (inf1 !== ((c <= 3) ? 2'd1 : 2'd0)) begin
                    failures++; $display("FAIL x0_inflight cyc=%0d got=%0d exp=%0d", c, inf1, (c <= 3) ? 1 : 0);
                end
            end
            step();
        end
    endtask

    task automatic test_hazards();
        logic [31:0] ex [7];
        logic [4:0]  rds [3];
        rds[0] = 5'd5; rds[1] = 5'd5; rds[2] = 5'd9;
        ex[0] = 32'h20; ex[1] = 32'h20; ex[2] = 32'h220; ex[3] = 32'h220;
        ex[4] = 32'h220; ex[5] = 32'h200; ex[6] = 32'h0;
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 3) begin
                v1 = 1; a1 = 32'd1; b1 = 32'd1; t1 = 2'b00; rd1 = rds[c];
            end
            #1;
            checks++;
            if (hz1 !== ex[c]) begin
                failures++; $display("FAIL hazard_map cyc=%0d got=%h exp=%h", c, hz1, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 5; c++) begin
            idle();
            ordy1 = 0;
            if (c < 2) begin
                v1 = 1; a1 = 32'd11; b1 = 32'd13; t1 = 2'b00; rd1 = 5'(20 + c);
            end
            if (c == 3) rst = 1;
            #1;
            if (c == 3) begin
                checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL rstmid_held got=%0b exp=1", ov1); end
            end
            if (c == 4) begin
                rst = 0;
                #1;
                checks++;
                if (ov1 !== 1'b0 || od1 !== 32'h0 || ord1 !== 5'd0 || hz1 !== 32'h0 || inf1 !== 2'd0 || irdy1 !== 1'b1) begin
                    failures++;
                    $display("FAIL rstmid_outputs got v=%0b d=%h rd=%0d hz=%h inf=%0d rdy=%0b exp 0/0/0/0/0/1", ov1, od1, ord1, hz1, inf1, irdy1);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back_x64();
        logic [63:0] ea [4];
        logic [63:0] eb [4];
        logic [63:0] ex [4];
        ea[0] = 64'd7;                  eb[0] = 64'hFFFFFFFFFFFFFFFD; ex[0] = 64'hFFFFFFFFFFFFFFEB;
        ea[1] = 64'h8000000000000000;   eb[1] = 64'h8000000000000000; ex[1] = 64'h4000000000000000;
        ea[2] = 64'hFFFFFFFFFFFFFFFF;   eb[2] = 64'hFFFFFFFFFFFFFFFF; ex[2] = 64'hFFFFFFFFFFFFFFFF;
        ea[3] = 64'hFFFFFFFFFFFFFFFF;   eb[3] = 64'hFFFFFFFFFFFFFFFF; ex[3] = 64'hFFFFFFFFFFFFFFFE;
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 4) begin
                v2 = 1; a2 = ea[c]; b2 = eb[c]; t2 = 2'(c); rd2 = 5'(c + 1);
            end
            #1;
            if (c == 0 || c == 5) begin
                checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL x64_idle_valid cyc=%0d got=%0b exp=0", c, ov2); end
            end else begin
                checks++;
                if (ov2 !== 1'b1 || od2 !== ex[c-1] || ord2 !== 5'(c)) begin
                    failures++;
                    $display("FAIL x64_result cyc=%0d got v=%0b d=%h rd=%0d exp v=1 d=%h rd=%0d", c, ov2, od2, ord2, ex[c-1], c);
                end
            end
            step();
        end
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
        test_reset();
        test_product_select();
        test_backpressure();
        test_flush();
        test_x0_dest();
        test_hazards();
        test_reset_midop();
        test_back_to_back_x64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
